// File: rtl/write_axi256_hls_dl_pkg.sv
// Shared types and helpers for the write_axi256 HLS dataflow deadlock
// detection logic: controller state encoding, ID width derivation and the
// lowest-set-index priority pick used by the controller and the detect-unit
// wrappers.
package write_axi256_hls_dl_pkg;

    // Controller sequence: confirm, strobe origin, follow token, stream report, wait for ack
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ORIGIN = 3'd1,
        TRACE  = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } dl_state_e;

    // Widest process vector the priority pick accepts
    localparam int VEC_MAX = 32;

    // Process ID width; a single process still needs a 1-bit ID
    function automatic int id_width(input int proc_num);
        if (proc_num <= 1) begin
            return 1;
        end else begin
            return $clog2(proc_num);
        end
    endfunction

    // Lowest set bit index of a zero-extended process vector (0 when empty)
    function automatic int unsigned lowest_set_idx(input logic [VEC_MAX-1:0] vec);
        int unsigned idx;
        idx = 32'd0;
        for (int i = VEC_MAX - 1; i >= 0; i--) begin
            idx = vec[i] ? 32'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/write_axi256_hls_dl_trace_buf.sv
// Trace buffer for the deadlock report: entries are written once in arrival
// order while the token is followed, then read back sequentially. Writes
// beyond capacity are silently dropped; the controller flags the overflow.
module write_axi256_hls_dl_trace_buf
    import write_axi256_hls_dl_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  ID_W  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = id_width(DEPTH)
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_data,
    input  logic             rd_adv,
    output logic [ID_W-1:0]  rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic [PTR_W-1:0] rd_ptr
);

    logic [ID_W-1:0]  mem_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             full_s;
    logic             wr_ok_s;
    logic [PTR_W-1:0] wr_ptr_s;

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign wr_ok_s  = wr_en && !full_s;
    assign wr_ptr_s = PTR_W'(count_r);

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_s;
    assign rd_ptr  = rd_ptr_r;

    // Entry storage: cleared with the buffer so no stale IDs survive a re-arm
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ID_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_ptr_s] <= wr_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Fill level: counts accepted writes only
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (wr_ok_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Read pointer: the controller never advances it past the last entry
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (rd_adv) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

endmodule

// File: rtl/write_axi256_hls_deadlock_report_ctrl.sv
// Central deadlock report controller for the write_axi256 HLS dataflow
// region. Confirms a persistent dl_detect indication, elects the lowest
// detecting process as origin, strobes it, follows the report token through
// the detect units and streams the recorded dependency cycle out as process
// IDs. Status flags stay sticky until the host acknowledges with clear.
module write_axi256_hls_deadlock_report_ctrl
    import write_axi256_hls_dl_pkg::*;
#(
    parameter int  PROC_NUM       = 4,
    parameter int  CONFIRM_CYCLES = 16,
    parameter int  TRACE_DEPTH    = 8,
    parameter int  TIMEOUT        = 1024,
    localparam int ID_W           = id_width(PROC_NUM)
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear,
    output logic                deadlock,
    output logic                timeout_err,
    output logic                trace_ovf,
    output logic [ID_W-1:0]     origin_id,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [ID_W-1:0]     rpt_id,
    output logic                rpt_last,
    input  logic                clear
);

    localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W  = $clog2(TRACE_DEPTH + 1);
    localparam int PTR_W  = id_width(TRACE_DEPTH);

    localparam logic [CONF_W-1:0]   CONF_TERM = CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_TERM  = TMO_W'(TIMEOUT - 1);
    localparam logic [PROC_NUM-1:0] ONE_LSB   = PROC_NUM'(1);

    dl_state_e           state_r;
    dl_state_e           state_s;
    logic [CONF_W-1:0]   conf_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [PROC_NUM-1:0] origin_vec_r;
    logic                deadlock_r;
    logic                timeout_err_r;
    logic                trace_ovf_r;
    logic [ID_W-1:0]     origin_id_r;

    logic                any_detect_s;
    logic                conf_hit_s;
    logic [ID_W-1:0]     det_id_s;
    logic                tok_any_s;
    logic [ID_W-1:0]     tok_id_s;
    logic                returned_s;
    logic                tmo_hit_s;
    logic                rpt_valid_s;
    logic                rpt_fire_s;
    logic                rpt_last_s;

    logic                buf_clr_s;
    logic                buf_wr_s;
    logic [ID_W-1:0]     buf_wr_data_s;
    logic                buf_rd_adv_s;
    logic [ID_W-1:0]     buf_rd_data_s;
    logic [CNT_W-1:0]    buf_count_s;
    logic                buf_full_s;
    logic [PTR_W-1:0]    buf_rd_ptr_s;

    assign any_detect_s = |dl_detect_vec;
    assign conf_hit_s   = any_detect_s && (conf_cnt_r == CONF_TERM);
    assign det_id_s     = ID_W'(lowest_set_idx(VEC_MAX'(dl_detect_vec)));
    assign tok_any_s    = |token_seen_vec;
    assign tok_id_s     = ID_W'(lowest_set_idx(VEC_MAX'(token_seen_vec)));
    assign tmo_hit_s    = (tmo_cnt_r == TMO_TERM);

    // Token back at the origin is acted on in the same cycle it is seen
    assign returned_s  = (state_r == TRACE) && token_seen_vec[origin_id_r];
    assign token_clear = returned_s ? (ONE_LSB << origin_id_r) : {PROC_NUM{1'b0}};

    assign rpt_valid_s = (state_r == REPORT);
    assign rpt_fire_s  = rpt_valid_s && rpt_ready;
    assign rpt_last_s  = (CNT_W'(buf_rd_ptr_s) == (buf_count_s - CNT_W'(1)));

    assign rpt_valid   = rpt_valid_s;
    assign rpt_id      = rpt_valid_s ? buf_rd_data_s : {ID_W{1'b0}};
    assign rpt_last    = rpt_valid_s && rpt_last_s;
    assign origin_vec  = origin_vec_r;
    assign deadlock    = deadlock_r;
    assign timeout_err = timeout_err_r;
    assign trace_ovf   = trace_ovf_r;
    assign origin_id   = origin_id_r;

    write_axi256_hls_dl_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .ID_W  (ID_W)
    ) u_trace_buf (
        .clock   (clock),
        .reset   (reset),
        .clr     (buf_clr_s),
        .wr_en   (buf_wr_s),
        .wr_data (buf_wr_data_s),
        .rd_adv  (buf_rd_adv_s),
        .rd_data (buf_rd_data_s),
        .count   (buf_count_s),
        .full    (buf_full_s),
        .rd_ptr  (buf_rd_ptr_s)
    );

    // Controller state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus trace buffer write/read/clear control
    always_comb begin
        state_s       = state_r;
        buf_wr_s      = 1'b0;
        buf_wr_data_s = {ID_W{1'b0}};
        buf_rd_adv_s  = 1'b0;
        buf_clr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (conf_hit_s) begin
                    state_s       = ORIGIN;
                    buf_wr_s      = 1'b1;
                    buf_wr_data_s = det_id_s;
                end else begin
                    state_s = IDLE;
                end
            end
            ORIGIN: begin
                state_s = TRACE;
            end
            TRACE: begin
                if (returned_s) begin
                    state_s = REPORT;
                end else begin
                    if (tok_any_s) begin
                        buf_wr_s      = 1'b1;
                        buf_wr_data_s = tok_id_s;
                    end else begin
                        buf_wr_s = 1'b0;
                    end
                    if (tmo_hit_s) begin
                        state_s = REPORT;
                    end else begin
                        state_s = TRACE;
                    end
                end
            end
            REPORT: begin
                if (rpt_fire_s) begin
                    if (rpt_last_s) begin
                        state_s = HALT;
                    end else begin
                        state_s      = REPORT;
                        buf_rd_adv_s = 1'b1;
                    end
                end else begin
                    state_s = REPORT;
                end
            end
            HALT: begin
                if (clear) begin
                    state_s   = IDLE;
                    buf_clr_s = 1'b1;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Confirmation counter, trace timer, origin latch/strobe and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            conf_cnt_r    <= {CONF_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            origin_vec_r  <= {PROC_NUM{1'b0}};
            deadlock_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            trace_ovf_r   <= 1'b0;
            origin_id_r   <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!any_detect_s) begin
                        conf_cnt_r <= {CONF_W{1'b0}};
                    end else if (conf_hit_s) begin
                        origin_id_r  <= det_id_s;
                        deadlock_r   <= 1'b1;
                        origin_vec_r <= ONE_LSB << det_id_s;
                    end else begin
                        conf_cnt_r <= conf_cnt_r + CONF_W'(1);
                    end
                end
                ORIGIN: begin
                    origin_vec_r <= {PROC_NUM{1'b0}};
                    tmo_cnt_r    <= {TMO_W{1'b0}};
                end
                TRACE: begin
                    if (!returned_s) begin
                        if (tmo_hit_s) begin
                            timeout_err_r <= 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                        end
                        if (tok_any_s && buf_full_s) begin
                            trace_ovf_r <= 1'b1;
                        end else begin
                            trace_ovf_r <= trace_ovf_r;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r;
                    end
                end
                REPORT: begin
                    conf_cnt_r <= conf_cnt_r;
                end
                HALT: begin
                    if (clear) begin
                        conf_cnt_r    <= {CONF_W{1'b0}};
                        tmo_cnt_r     <= {TMO_W{1'b0}};
                        deadlock_r    <= 1'b0;
                        timeout_err_r <= 1'b0;
                        trace_ovf_r   <= 1'b0;
                        origin_id_r   <= {ID_W{1'b0}};
                    end else begin
                        deadlock_r <= deadlock_r;
                    end
                end
                default: begin
                    origin_vec_r <= {PROC_NUM{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_axi256_hls_deadlock_report_ctrl.sv
// Randomized self-checking bench for the deadlock report controller.
// The driver builds each scenario's token sequence, a reference model derives
// the expected report stream and flags from the behavioural rules, the
// expected stream is queued, and a negedge monitor checks every presented
// report entry against the queue head.
module tb_write_axi256_hls_deadlock_report_ctrl;

    localparam int PROC_NUM       = 4;
    localparam int CONFIRM_CYCLES = 16;
    localparam int TRACE_DEPTH    = 8;
    localparam int TIMEOUT        = 1024;
    localparam int ID_W           = 2;

    logic                clock;
    logic                reset;
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [PROC_NUM-1:0] token_seen_vec;
    logic [PROC_NUM-1:0] origin_vec;
    logic [PROC_NUM-1:0] token_clear;
    logic                deadlock;
    logic                timeout_err;
    logic                trace_ovf;
    logic [ID_W-1:0]     origin_id;
    logic                rpt_valid;
    logic                rpt_ready;
    logic [ID_W-1:0]     rpt_id;
    logic                rpt_last;
    logic                clear;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } rpt_exp_t;

    rpt_exp_t   exp_q[$];
    logic [3:0] tok_q[$];
    int         m_ids[$];
    bit         m_ovf;
    bit         m_tmo;
    bit         m_ret;
    int         m_used;
    int         checks = 0;
    int         errors = 0;

    write_axi256_hls_deadlock_report_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .dl_detect_vec  (dl_detect_vec),
        .token_seen_vec (token_seen_vec),
        .origin_vec     (origin_vec),
        .token_clear    (token_clear),
        .deadlock       (deadlock),
        .timeout_err    (timeout_err),
        .trace_ovf      (trace_ovf),
        .origin_id      (origin_id),
        .rpt_valid      (rpt_valid),
        .rpt_ready      (rpt_ready),
        .rpt_id         (rpt_id),
        .rpt_last       (rpt_last),
        .clear          (clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int low_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: origin first, one entry per non-returning token hop
    // (lowest index), capped at TRACE_DEPTH; stop on return or timeout.
    task automatic run_model(input int org);
        m_ids.delete();
        m_ids.push_back(org);
        m_ovf = 1'b0; m_tmo = 1'b0; m_ret = 1'b0; m_used = 0;
        for (int i = 0; i < tok_q.size(); i++) begin
            m_used = i + 1;
            if (tok_q[i][org]) begin
                m_ret = 1'b1;
                break;
            end
            if (tok_q[i] != 4'd0) begin
                if (m_ids.size() < TRACE_DEPTH) m_ids.push_back(low_idx(tok_q[i]));
                else m_ovf = 1'b1;
            end
            if (i == TIMEOUT - 1) begin
                m_tmo = 1'b1;
                break;
            end
        end
    endtask

    task automatic gen_tokens(input int org, input int n_hops, input bit to_timeout);
        logic [3:0] mask;
        logic [3:0] t;
        int len;
        mask = 4'b0001 << org;
        tok_q.delete();
        len = to_timeout ? TIMEOUT + 4 : n_hops;
        for (int i = 0; i < len; i++) begin
            t = 4'($urandom_range(0, 15)) & ~mask;
            if (to_timeout && $urandom_range(0, 99) != 0) t = 4'd0;
            tok_q.push_back(t);
        end
        if (!to_timeout) tok_q.push_back(mask | 4'($urandom_range(0, 15)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_origin_vec"},  32'(origin_vec),  32'd0);
        chk({tag, "_token_clear"}, 32'(token_clear), 32'd0);
        chk({tag, "_deadlock"},    32'(deadlock),    32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_trace_ovf"},   32'(trace_ovf),   32'd0);
        chk({tag, "_origin_id"},   32'(origin_id),   32'd0);
        chk({tag, "_rpt_valid"},   32'(rpt_valid),   32'd0);
        chk({tag, "_rpt_id"},      32'(rpt_id),      32'd0);
        chk({tag, "_rpt_last"},    32'(rpt_last),    32'd0);
    endtask

    // Full detect -> trace -> report -> clear sequence for one deadlock
    task automatic scenario(input logic [3:0] det_fixed, input int n_hops, input bit to_timeout,
                            input bit preset, input bit rdy_pat, input bit rst_in_report);
        logic [3:0] v;
        logic [3:0] pat;
        int org;
        int budget;
        int rp;
        int start;
        pat = 4'b1101;
        v = det_fixed;
        for (int c = 0; c < CONFIRM_CYCLES; c++) begin
            v = (det_fixed != 4'd0) ? det_fixed : 4'($urandom_range(1, 15));
            dl_detect_vec = v;
            tick();
            if (c < CONFIRM_CYCLES - 1) chk("deadlock_early", 32'(deadlock), 32'd0);
        end
        org = low_idx(v);
        chk("deadlock_set", 32'(deadlock), 32'd1);
        chk("origin_id", 32'(origin_id), 32'(org));
        chk("origin_vec_pulse", 32'(origin_vec), 32'd1 << org);
        if (!preset) gen_tokens(org, n_hops, to_timeout);
        run_model(org);
        for (int k = 0; k < m_ids.size(); k++) begin
            exp_q.push_back('{id: ID_W'(m_ids[k]), last: (k == m_ids.size() - 1)});
        end
        // ORIGIN cycle: a token at the origin is not yet a return
        dl_detect_vec  = 4'($urandom_range(0, 15));
        token_seen_vec = (4'b0001 << org) | 4'($urandom_range(0, 15));
        #1;
        chk("token_clear_origin", 32'(token_clear), 32'd0);
        tick();
        chk("origin_vec_end", 32'(origin_vec), 32'd0);
        for (int i = 0; i < m_used; i++) begin
            token_seen_vec = tok_q[i];
            dl_detect_vec  = 4'($urandom_range(0, 15));
            clear          = ($urandom_range(0, 3) == 0);
            #1;
            chk("token_clear", 32'(token_clear),
                (m_ret && i == m_used - 1) ? (32'd1 << org) : 32'd0);
            tick();
        end
        token_seen_vec = 4'd0;
        dl_detect_vec  = 4'd0;
        clear          = 1'b0;
        budget = 0;
        rp = 0;
        start = exp_q.size();
        while (exp_q.size() != 0 && budget < 200) begin
            if (rst_in_report && exp_q.size() < start) begin
                reset = 1'b1;
                exp_q.delete();
                tick();
                chk_zero("rst_mid_report");
                reset = 1'b0;
                rpt_ready = 1'b0;
                return;
            end
            rpt_ready = (rdy_pat && rp < 4) ? pat[rp] : 1'($urandom_range(0, 1));
            rp++;
            tick();
            budget++;
        end
        rpt_ready = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rpt_stream_budget: %0d entries still pending after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        chk("rpt_valid_halt", 32'(rpt_valid), 32'd0);
        chk("deadlock_halt", 32'(deadlock), 32'd1);
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        chk("trace_ovf", 32'(trace_ovf), 32'(m_ovf));
        chk("origin_id_halt", 32'(origin_id), 32'(org));
        repeat (3) begin
            dl_detect_vec = 4'($urandom_range(0, 15));
            tick();
        end
        chk("flags_hold", 32'({deadlock, timeout_err, trace_ovf}), 32'({1'b1, m_tmo, m_ovf}));
        chk("rpt_valid_hold", 32'(rpt_valid), 32'd0);
        dl_detect_vec = 4'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_zero("after_clear");
    endtask

    // Report stream monitor: every presented entry must match the queue head
    always @(negedge clock) begin
        if (!reset && rpt_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rpt_unexpected: got id %0d last %0d, none expected", rpt_id, rpt_last);
            end else begin
                chk("rpt_id", 32'(rpt_id), 32'(exp_q[0].id));
                chk("rpt_last", 32'(rpt_last), 32'(exp_q[0].last));
                if (rpt_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        dl_detect_vec = 4'd0;
        token_seen_vec = 4'd0;
        rpt_ready = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;

        // Fixed single detector, short returning trace
        scenario(4'b0100, 5, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle gap restarts confirmation
        for (int c = 0; c < CONFIRM_CYCLES - 1; c++) begin
            dl_detect_vec = 4'b0010;
            tick();
            chk("gap_no_deadlock", 32'(deadlock), 32'd0);
        end
        dl_detect_vec = 4'b0000;
        tick();
        chk("gap_cycle", 32'(deadlock), 32'd0);
        scenario(4'b0010, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Origin 0, hops 1 and 3, return; ready pattern 1,0,1,1
        tok_q.delete();
        tok_q.push_back(4'b0010);
        tok_q.push_back(4'b1000);
        tok_q.push_back(4'b0001);
        scenario(4'b0001, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Origin 1, token never returns
        scenario(4'b0010, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overflow: ten hops into an eight-entry buffer
        tok_q.delete();
        for (int i = 0; i < 10; i++) tok_q.push_back(4'($urandom_range(1, 7)));
        tok_q.push_back(4'b1000 | 4'($urandom_range(0, 7)));
        scenario(4'b1000, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Exactly full: seven hops fill the buffer without overflow
        tok_q.delete();
        for (int i = 0; i < 7; i++) tok_q.push_back(4'($urandom_range(1, 7)));
        tok_q.push_back(4'b1000);
        scenario(4'b1000, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the report stream, then a normal re-detect
        tok_q.delete();
        tok_q.push_back(4'b0010);
        tok_q.push_back(4'b0100);
        tok_q.push_back(4'b0001);
        scenario(4'b0001, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        scenario(4'b0100, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized detectors, hop counts and the occasional timeout
        for (int s = 0; s < 10; s++) begin
            scenario(4'd0, $urandom_range(0, 14), ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
